// File: rtl/g_macro_pkg.sv
// rtl/g_macro_pkg.sv - shared constants and helpers for the g_* macro cells
//
// Contents:
//   G_MAX_HOLD   : largest stretch length any g_* cell supports
//   g_cnt_width  : stretch counter width for a given HOLD, never below one bit

package g_macro_pkg;

    localparam int G_MAX_HOLD = 255;

    // Enough bits to hold the value HOLD without wrapping; a zero-length
    // stretch still gets a one-bit counter so the vector is never empty.
    function automatic int g_cnt_width(input int hold);
        int w_bits;
        w_bits = $clog2(hold + 1);
        return (w_bits < 1) ? 1 : w_bits;
    endfunction

endpackage

// File: rtl/g_sync2.sv
// rtl/g_sync2.sv - one-bit two-flop synchroniser with clock enable
//
// Parameters:
//   RST_VAL : level both flops take on reset
// Ports:
//   CK : clock, rising edge
//   CD : synchronous active-high reset
//   CE : clock enable, both stages hold when low
//   D  : asynchronous input bit
//   Q  : synchronised output bit

module g_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic CK,
    input  logic CD,
    input  logic CE,
    input  logic D,
    output logic Q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge CK) begin
        if (CD) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else if (CE) begin
            r_meta <= D;
            r_sync <= r_meta;
        end
    end

    assign Q = r_sync;

endmodule

// File: rtl/g_orn_stretch.sv
// rtl/g_orn_stretch.sv - polarity-corrected OR with registered pulse stretcher
//
// Optional feature: define G_ORN_STRETCH_SYNC_EN to put a g_sync2 on every
// bit of A ahead of the polarity correction (Y/RISE latency then 3 cycles).
//
// Parameters:
//   WIDTH    : number of OR inputs (1..32)
//   INV_MASK : bit i set means A[i] is active-low
//   HOLD     : extra cycles Y stays high after the last hit (0..255)
// Ports:
//   CK   : clock, rising edge
//   CD   : synchronous active-high reset, wins over CE and hit
//   CE   : clock enable for all state
//   A    : raw OR inputs
//   YC   : combinational OR of the polarity-corrected inputs
//   Y    : registered, stretched OR result
//   RISE : one-cycle registered pulse on each 0->1 transition of Y

module g_orn_stretch
    import g_macro_pkg::*;
#(
    parameter int               WIDTH    = 2,
    parameter logic [WIDTH-1:0] INV_MASK = '1,
    parameter int               HOLD     = 0
) (
    input  logic             CK,
    input  logic             CD,
    input  logic             CE,
    input  logic [WIDTH-1:0] A,
    output logic             YC,
    output logic             Y,
    output logic             RISE
);

    // Out-of-range HOLD values are clamped rather than allowed to wrap.
    localparam int              HOLD_C = (HOLD > G_MAX_HOLD) ? G_MAX_HOLD : HOLD;
    localparam int              CW     = g_cnt_width(HOLD_C);
    localparam logic [CW-1:0]   HOLD_V = CW'(HOLD_C);

    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_e;
    logic             w_hit;
    logic             w_y_next;

    logic             r_y;
    logic             r_rise;
    logic [CW-1:0]    r_cnt;

`ifdef G_ORN_STRETCH_SYNC_EN
    // Each synchroniser resets to its own mask bit so the corrected value
    // is 0 (no hit) straight out of reset.
    for (genvar i = 0; i < WIDTH; i++) begin : g_sync
        g_sync2 #(
            .RST_VAL(INV_MASK[i])
        ) u_sync (
            .CK(CK),
            .CD(CD),
            .CE(CE),
            .D (A[i]),
            .Q (w_a_in[i])
        );
    end
`else
    assign w_a_in = A;
`endif

    assign w_e   = w_a_in ^ INV_MASK;
    assign w_hit = |w_e;
    assign YC    = w_hit;

    // Y is high on the next edge whenever there is a fresh hit or the
    // stretch counter still has cycles left.
    always_comb begin
        w_y_next = 1'b0;
        if (w_hit || (r_cnt != '0)) begin
            w_y_next = 1'b1;
        end
    end

    always_ff @(posedge CK) begin
        if (CD) begin
            r_y    <= 1'b0;
            r_rise <= 1'b0;
            r_cnt  <= '0;
        end else if (CE) begin
            // Retrigger while Y is already high gives no new RISE.
            r_rise <= w_y_next & ~r_y;
            r_y    <= w_y_next;
            if (w_hit) begin
                r_cnt <= HOLD_V;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign Y    = r_y;
    assign RISE = r_rise;

endmodule

// File: tb/tb_g_orn_stretch.sv
// tb/tb_g_orn_stretch.sv - self-checking bench for g_orn_stretch (HOLD 0, 3, 5)

module tb_g_orn_stretch;

    localparam int BIG = 1000;

    logic       CK = 1'b0;
    logic       CD;
    logic       CE;
    logic [1:0] A;

    logic yc0, y0, r0;
    logic yc3, y3, r3;
    logic yc5, y5, r5;

    g_orn_stretch #(.WIDTH(2), .INV_MASK(2'b11), .HOLD(0)) u_dut0 (
        .CK(CK), .CD(CD), .CE(CE), .A(A), .YC(yc0), .Y(y0), .RISE(r0)
    );
    g_orn_stretch #(.WIDTH(2), .INV_MASK(2'b11), .HOLD(3)) u_dut3 (
        .CK(CK), .CD(CD), .CE(CE), .A(A), .YC(yc3), .Y(y3), .RISE(r3)
    );
    g_orn_stretch #(.WIDTH(2), .INV_MASK(2'b11), .HOLD(5)) u_dut5 (
        .CK(CK), .CD(CD), .CE(CE), .A(A), .YC(yc5), .Y(y5), .RISE(r5)
    );

    always #5 CK = ~CK;

    int checks   = 0;
    int failures = 0;

    // Reference model: Y is high iff a hit was seen within the last HOLD+1
    // enabled edges since reset; tracked as "enabled edges since last hit".
    int hold_of[3] = '{0, 3, 5};
    int m_age[3];
    bit m_y[3];
    bit m_rise[3];
    bit m_s1, m_s2;

    logic s_yc0, s_yc5;
    bit   s_yc_exp;

    typedef struct {
        bit         cd;
        bit         ce;
        logic [1:0] a;
        bit         yc;
        bit [2:0]   y;     // {HOLD5, HOLD3, HOLD0}
        bit [2:0]   rise;
    } vec_t;

    vec_t tbl[16];

    function automatic bit hit_of(input logic [1:0] a);
        return (a ^ 2'b11) != 2'b00;
    endfunction

    function automatic bit model_yc(input logic [1:0] a);
`ifdef G_ORN_STRETCH_SYNC_EN
        return m_s2;
`else
        return hit_of(a);
`endif
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit cd, input bit ce, input bit h);
        bit eff;
        bit ynew;
        if (cd) begin
            for (int k = 0; k < 3; k++) begin
                m_age[k]  = BIG;
                m_y[k]    = 1'b0;
                m_rise[k] = 1'b0;
            end
            m_s1 = 1'b0;
            m_s2 = 1'b0;
        end else if (ce) begin
`ifdef G_ORN_STRETCH_SYNC_EN
            eff  = m_s2;
            m_s2 = m_s1;
            m_s1 = h;
`else
            eff = h;
`endif
            for (int k = 0; k < 3; k++) begin
                if (eff) m_age[k] = 0;
                else if (m_age[k] < BIG) m_age[k] = m_age[k] + 1;
                ynew      = (m_age[k] <= hold_of[k]);
                m_rise[k] = ynew && !m_y[k];
                m_y[k]    = ynew;
            end
        end
    endtask

    task automatic step(input bit cd, input bit ce, input logic [1:0] a);
        CD = cd;
        CE = ce;
        A  = a;
        #1;
        s_yc0    = yc0;
        s_yc5    = yc5;
        s_yc_exp = model_yc(a);
        @(posedge CK);
        model_edge(cd, ce, hit_of(a));
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected finish before t=400000");
        $fatal(1);
    end

    initial begin
        int n_y0, n_y3, n_y5, n_r0, n_r3, n_r5;
        logic [1:0] ra;
        bit rcd, rce;

        for (int k = 0; k < 3; k++) begin
            m_age[k] = BIG; m_y[k] = 1'b0; m_rise[k] = 1'b0;
        end
        m_s1 = 1'b0; m_s2 = 1'b0;
        CD = 1'b1; CE = 1'b1; A = 2'b11;

`ifndef G_ORN_STRETCH_SYNC_EN
        tbl[0]  = '{1'b1, 1'b1, 2'b11, 1'b0, 3'b000, 3'b000};
        tbl[1]  = '{1'b0, 1'b1, 2'b11, 1'b0, 3'b000, 3'b000};
        tbl[2]  = '{1'b0, 1'b1, 2'b01, 1'b1, 3'b111, 3'b111};
        tbl[3]  = '{1'b0, 1'b1, 2'b11, 1'b0, 3'b110, 3'b000};
        tbl[4]  = '{1'b0, 1'b1, 2'b11, 1'b0, 3'b110, 3'b000};
        tbl[5]  = '{1'b0, 1'b1, 2'b10, 1'b1, 3'b111, 3'b001};
        tbl[6]  = '{1'b0, 1'b1, 2'b11, 1'b0, 3'b110, 3'b000};
        tbl[7]  = '{1'b0, 1'b0, 2'b00, 1'b1, 3'b110, 3'b000};
        tbl[8]  = '{1'b0, 1'b0, 2'b11, 1'b0, 3'b110, 3'b000};
        tbl[9]  = '{1'b0, 1'b1, 2'b11, 1'b0, 3'b110, 3'b000};
        tbl[10] = '{1'b1, 1'b1, 2'b00, 1'b1, 3'b000, 3'b000};
        tbl[11] = '{1'b0, 1'b1, 2'b11, 1'b0, 3'b000, 3'b000};
        tbl[12] = '{1'b0, 1'b0, 2'b00, 1'b1, 3'b000, 3'b000};
        tbl[13] = '{1'b0, 1'b1, 2'b00, 1'b1, 3'b111, 3'b111};
        tbl[14] = '{1'b1, 1'b0, 2'b11, 1'b0, 3'b000, 3'b000};
        tbl[15] = '{1'b0, 1'b1, 2'b11, 1'b0, 3'b000, 3'b000};

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].cd, tbl[i].ce, tbl[i].a);
            chk($sformatf("tbl%0d_yc", i), s_yc0, tbl[i].yc);
            chk($sformatf("tbl%0d_y0", i), y0, tbl[i].y[0]);
            chk($sformatf("tbl%0d_y3", i), y3, tbl[i].y[1]);
            chk($sformatf("tbl%0d_y5", i), y5, tbl[i].y[2]);
            chk($sformatf("tbl%0d_rise0", i), r0, tbl[i].rise[0]);
            chk($sformatf("tbl%0d_rise3", i), r3, tbl[i].rise[1]);
            chk($sformatf("tbl%0d_rise5", i), r5, tbl[i].rise[2]);
        end

        // Single-cycle hit: high time is HOLD+1 cycles, one RISE each.
        step(1'b1, 1'b1, 2'b11);
        n_y0 = 0; n_y3 = 0; n_y5 = 0; n_r0 = 0; n_r3 = 0; n_r5 = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, (k == 0) ? 2'b01 : 2'b11);
            n_y0 += int'(y0); n_y3 += int'(y3); n_y5 += int'(y5);
            n_r0 += int'(r0); n_r3 += int'(r3); n_r5 += int'(r5);
        end
        chk("pulse_y0_len1", n_y0 == 1, 1'b1);
        chk("pulse_y3_len4", n_y3 == 4, 1'b1);
        chk("pulse_y5_len6", n_y5 == 6, 1'b1);
        chk("pulse_rise_once", (n_r0 == 1) && (n_r3 == 1) && (n_r5 == 1), 1'b1);

        // Retrigger at cycle 2: continuous high after edges 0..5, single RISE.
        step(1'b1, 1'b1, 2'b11);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, (k == 0 || k == 2) ? 2'b10 : 2'b11);
            chk($sformatf("retrig_y3_e%0d", k), y3, (k <= 5));
            chk($sformatf("retrig_rise3_e%0d", k), r3, (k == 0));
        end

        // CE low for 4 cycles mid-stretch: Y frozen, enabled high time unchanged.
        step(1'b1, 1'b1, 2'b11);
        n_y3 = 0; n_y5 = 0;
        step(1'b0, 1'b1, 2'b00);
        n_y3 += int'(y3); n_y5 += int'(y5);
        step(1'b0, 1'b1, 2'b11);
        n_y3 += int'(y3); n_y5 += int'(y5);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 2'b11);
            chk($sformatf("freeze_y3_c%0d", k), y3, 1'b1);
            chk($sformatf("freeze_rise3_c%0d", k), r3, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 2'b11);
            n_y3 += int'(y3); n_y5 += int'(y5);
        end
        chk("freeze_y3_total4", n_y3 == 4, 1'b1);
        chk("freeze_y5_total6", n_y5 == 6, 1'b1);
`endif

        // Randomised run against the reference model.
        step(1'b1, 1'b1, 2'b11);
        for (int i = 0; i < 2000; i++) begin
            rcd = ($urandom_range(99) < 3);
            rce = ($urandom_range(99) < 80);
            if ($urandom_range(2) != 0) ra = 2'b11;
            else ra = 2'($urandom_range(3));
            step(rcd, rce, ra);
            chk("rand_yc0", s_yc0, s_yc_exp);
            chk("rand_yc5", s_yc5, s_yc_exp);
            chk("rand_y0", y0, m_y[0]);
            chk("rand_y3", y3, m_y[1]);
            chk("rand_y5", y5, m_y[2]);
            chk("rand_rise0", r0, m_rise[0]);
            chk("rand_rise3", r3, m_rise[1]);
            chk("rand_rise5", r5, m_rise[2]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/g_orn_stretch.md
G_ORN_STRETCH -- requirements
Module: g_orn_stretch

Interface
REQ-001 Parameter WIDTH, default 2: number of OR inputs, legal range 1..32.
REQ-002 Parameter INV_MASK, default all ones (WIDTH bits): bit i = 1 means input A[i] is active-low.
REQ-003 Parameter HOLD, default 0: number of extra cycles Y stays high after the last hit, legal range 0..255.
REQ-004 Port CK, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port CD, input, 1: reset, synchronous and active-high.
REQ-006 Port CE, input, 1: clock enable for all state.
REQ-007 Port A, input, WIDTH: raw OR inputs.
REQ-008 Port YC, output, 1: combinational OR of the polarity-corrected inputs.
REQ-009 Port Y, output, 1: registered and stretched OR result.
REQ-010 Port RISE, output, 1: one-cycle registered pulse on each 0->1 transition of Y.

Function
REQ-011 The corrected vector SHALL be e = A XOR INV_MASK, and hit SHALL be the OR-reduction of e.
REQ-012 YC SHALL equal hit with zero latency and SHALL be independent of CK, CD and CE.
REQ-013 The stretch counter cnt SHALL be max(1, ceil(log2(HOLD+1))) bits wide and SHALL never wrap.
REQ-014 On a CK edge with CD=0, CE=1 and hit=1, the block SHALL set Y<=1 and cnt<=HOLD.
REQ-015 On a CK edge with CD=0, CE=1, hit=0 and cnt!=0, the block SHALL set Y<=1 and cnt<=cnt-1.
REQ-016 On a CK edge with CD=0, CE=1, hit=0 and cnt=0, the block SHALL set Y<=0.
REQ-017 Y SHALL therefore rise one cycle after hit and fall HOLD+1 cycles after hit's last high sample.
REQ-018 With HOLD=0, Y SHALL be hit delayed by one enabled cycle.
REQ-019 A hit occurring while cnt!=0 SHALL reload cnt to HOLD (retrigger); no pulses are merged or lost.
REQ-020 RISE SHALL be 1 for exactly one enabled cycle, in the same cycle Y first reads 1 after reading 0.
REQ-021 RISE SHALL NOT assert on a retrigger while Y is already 1.
REQ-022 When CE=0, Y, RISE and cnt SHALL hold their values, and sync stages (if present) SHALL hold.
REQ-023 CD SHALL take priority over CE and over hit.

Reset
REQ-024 On a CK edge with CD=1, the block SHALL set Y<=0, RISE<=0, cnt<=0, and clear all sync flops to the deasserted (post-mask 0) level.
REQ-025 A reset arriving mid-stretch SHALL abort the stretch; the first enabled edge after CD falls follows REQ-014..016 from cnt=0.
REQ-026 RISE SHALL NOT fire on the first cycle after reset unless hit was 1 on that edge.

Configuration
REQ-027 Macro G_ORN_STRETCH_SYNC_EN, when defined, SHALL insert a 2-flop synchroniser per bit of A ahead of the XOR.
- Synchroniser flops are gated by CE and reset per REQ-024; Y and RISE latency become 3 enabled cycles.
- YC SHALL then be derived from the synchronised vector.
REQ-028 Without G_ORN_STRETCH_SYNC_EN, A SHALL feed the XOR directly, with Y and RISE latency of 1 cycle.

Structure
REQ-029 Shared package g_macro_pkg SHALL hold the counter-width function (REQ-013) and the constant G_MAX_HOLD=255.
REQ-030 The synchroniser SHALL be the sub-module g_sync2 (one bit, CK/CD/CE/D/Q), instantiated WIDTH times under the macro.
REQ-031 The block SHALL contain no latches and no derived or gated clocks.

Verification
REQ-032 WIDTH=2, INV_MASK=2'b11, HOLD=0, A=2'b11 -> YC=0; A=2'b01 -> YC=1 immediately, Y=1 and RISE=1 on the next edge, RISE=0 one cycle later.
REQ-033 HOLD=3, one-cycle hit -> Y high for exactly 4 cycles; RISE high for 1 cycle.
REQ-034 HOLD=3, hits at cycles 0 and 2 -> Y continuously high cycles 1..6; a single RISE at cycle 1.
REQ-035 HOLD=5, CD=1 at cycle 2 of stretch -> Y=0 and cnt=0 next edge; no RISE after release while hit=0.
REQ-036 CE=0 for 4 cycles mid-stretch (HOLD=3) -> Y frozen at 1 and total high time = 4 enabled cycles.
REQ-037 With G_ORN_STRETCH_SYNC_EN defined, WIDTH=8, INV_MASK=8'h0F, A=8'h0F->8'h1F -> Y rises 3 cycles after the change.
